seg_streamer: RTL

Hardware source for the collision-detection datapath. Accepts a stream of voxel-coordinate path points, pairs each point with its predecessor to form line segments, and drives the detector's `in_val`/`x1..z2` input at a paced rate. Consumes the detector's `out_val`/`lineID` result stream into a hit counter. Sits between the G-code point parser and `CollisionDetect`, and replaces the file-driven stimulus in system builds.

---
 rtl/collision_pkg.sv | 34 +++
 rtl/seg_point_fifo.sv | 47 ++++
 rtl/seg_streamer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared types for the collision-detection datapath: coordinate/ID widths, point/segment records, streamer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package collision_pkg;

   localparam int COORD_W = 8;
   localparam int ID_W    = 8;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] z;
      logic               new_path;
      logic               last;
   } point_t;

   typedef struct packed {
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
      logic [COORD_W-1:0] z1;
      logic [COORD_W-1:0] x2;
      logic [COORD_W-1:0] y2;
      logic [COORD_W-1:0] z2;
      logic [ID_W-1:0]    id;
   } seg_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HAVE_PREV,
      S_GAP,
      S_DONE
   } state_t;

endpackage

// File: rtl/seg_point_fifo.sv
// Generic synchronous FIFO with full/empty flags; DEPTH must be a power of two.
// Latency: a word written at edge N is visible on rdata (and poppable) from edge N+1.
// Backpressure: writes while full and reads while empty are ignored; the caller gates on full/empty.
module seg_point_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/seg_streamer.sv
// Pairs path points into line segments and paces them into CollisionDetect; optional hit log (SEG_STREAMER_HIT_LOG_EN).
// Latency: point pushed at edge N is popped at N+1; its segment's in_val is high in the following cycle.
// Backpressure: pt_rdy drops when the point FIFO is full, during reset and once done; one segment per GAP+1 cycles.
module seg_streamer #(
   parameter int COORD_W    = collision_pkg::COORD_W,
   parameter int ID_W       = collision_pkg::ID_W,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP        = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pt_val,
   output logic               pt_rdy,
   input  logic [COORD_W-1:0] pt_x,
   input  logic [COORD_W-1:0] pt_y,
   input  logic [COORD_W-1:0] pt_z,
   input  logic               pt_new_path,
   input  logic               pt_last,
   output logic               in_val,
   output logic [COORD_W-1:0] x1,
   output logic [COORD_W-1:0] y1,
   output logic [COORD_W-1:0] z1,
   output logic [COORD_W-1:0] x2,
   output logic [COORD_W-1:0] y2,
   output logic [COORD_W-1:0] z2,
   output logic [ID_W-1:0]    seg_id,
   input  logic               out_val,
   input  logic [ID_W-1:0]    lineID,
   output logic               done,
   output logic [15:0]        hit_cnt,
   output logic [ID_W-1:0]    first_hit
);

   import collision_pkg::*;

   localparam int         PT_W     = 3*COORD_W + 2;
   localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   state_t             state, state_nxt;
   logic               fifo_full, fifo_empty;
   logic               push, pop, emit;
   logic [PT_W-1:0]    fifo_rdata;
   logic [COORD_W-1:0] cur_x, cur_y, cur_z;
   logic [COORD_W-1:0] prev_x, prev_y, prev_z;
   logic               cur_new_path, cur_last, same_pt;
   logic               last_pend;
   logic [ID_W-1:0]    seg_cnt;
   logic [3:0]         gap_cnt;

   assign pt_rdy = !reset && !fifo_full && (state != S_DONE);
   assign push   = pt_val && pt_rdy;
   assign done   = (state == S_DONE);

   seg_point_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PT_W)
   ) u_point_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata ({pt_x, pt_y, pt_z, pt_new_path, pt_last}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign {cur_x, cur_y, cur_z, cur_new_path, cur_last} = fifo_rdata;
   assign same_pt = (cur_x == prev_x) && (cur_y == prev_y) && (cur_z == prev_z);

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next state: a segment ending in a last point still drains its gap before DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (!fifo_empty)
               state_nxt = cur_last ? S_DONE : S_HAVE_PREV;
         S_HAVE_PREV:
            if (!fifo_empty) begin
               if (emit && (GAP != 0))
                  state_nxt = S_GAP;
               else if (cur_last)
                  state_nxt = S_DONE;
            end
         S_GAP:
            if (gap_cnt == GAP_LAST)
               state_nxt = last_pend ? S_DONE : S_HAVE_PREV;
         default: ;
      endcase
   end

   // FSM outputs: pop whenever a point is wanted; emit only for a real, non-zero-length segment.
   always_comb begin
      pop  = 1'b0;
      emit = 1'b0;
      case (state)
         S_IDLE:      pop = !fifo_empty;
         S_HAVE_PREV: begin
            pop  = !fifo_empty;
            emit = !fifo_empty && !cur_new_path && !same_pt;
         end
         default: ;
      endcase
   end

   // Segment datapath: previous point, registered segment outputs, ID counter and gap timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_x    <= '0;
         prev_y    <= '0;
         prev_z    <= '0;
         in_val    <= 1'b0;
         x1        <= '0;
         y1        <= '0;
         z1        <= '0;
         x2        <= '0;
         y2        <= '0;
         z2        <= '0;
         seg_id    <= '0;
         seg_cnt   <= '0;
         last_pend <= 1'b0;
         gap_cnt   <= '0;
      end else begin
         in_val <= emit;
         if (pop) begin
            prev_x <= cur_x;
            prev_y <= cur_y;
            prev_z <= cur_z;
         end
         if (emit) begin
            x1        <= prev_x;
            y1        <= prev_y;
            z1        <= prev_z;
            x2        <= cur_x;
            y2        <= cur_y;
            z2        <= cur_z;
            seg_id    <= seg_cnt;
            seg_cnt   <= seg_cnt + 1'b1;
            last_pend <= cur_last;
         end
         if (state == S_GAP)
            gap_cnt <= gap_cnt + 4'd1;
         else
            gap_cnt <= '0;
      end
   end

`ifdef SEG_STREAMER_HIT_LOG_EN
   logic hit_seen;

   // Count detector results (saturating) and capture the line ID of the first one.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt   <= '0;
         first_hit <= '0;
         hit_seen  <= 1'b0;
      end else if (out_val) begin
         if (hit_cnt != 16'hFFFF)
            hit_cnt <= hit_cnt + 16'd1;
         if (!hit_seen) begin
            first_hit <= lineID;
            hit_seen  <= 1'b1;
         end
      end
   end
`else
   logic unused_hit_inputs;
   assign unused_hit_inputs = ^{out_val, lineID};
   assign hit_cnt   = '0;
   assign first_hit = '0;
`endif

endmodule
